// File: rtl/poolb_next_reader_cu_pkg.sv
// Shared types and sizing helpers for the next-IFM bank reader control unit.
// Pure declarations, no logic; no latency.
// No flow control lives here.
package poolb_next_reader_cu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_FINISH  = 3'd3,
        ST_HANDOFF = 3'd4
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Never returns a zero width, so a single-entry range still gets a 1-bit bus.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int IFM_SIZE_DEF          = 3;
    localparam int IFM_DEPTH_DEF         = 16;
    localparam int NUMBER_OF_UNITS_DEF   = 3;
    localparam int MEM_READ_LATENCY_DEF  = 1;
    localparam int NUMBER_OF_BLOCKS_DEF  = ceil_div(IFM_DEPTH_DEF, NUMBER_OF_UNITS_DEF);
    localparam int ADDRESS_SIZE_IFM_DEF  = width_of(IFM_SIZE_DEF * IFM_SIZE_DEF);
    localparam int SEL_SIZE_DEF          = width_of(NUMBER_OF_BLOCKS_DEF);

endpackage

// File: rtl/poolb_next_reader_cu_if.sv
// Bundle of the producer handshake, memory read port, sink stream and downstream handshake.
// Wires only; no latency.
// sink_ready is the only backpressure input; the master stalls reads while it is low.
interface poolb_next_reader_cu_if
    import poolb_next_reader_cu_pkg::*;
#(
    parameter int ADDRESS_SIZE_IFM = ADDRESS_SIZE_IFM_DEF,
    parameter int SEL_SIZE         = SEL_SIZE_DEF
);
    logic                        start_from_previous;
    logic                        end_to_previous;
    logic                        sink_ready;
    logic                        ifm_enable_read;
    logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read;
    logic [SEL_SIZE-1:0]         ifm_sel_read;
    logic                        data_valid;
    logic                        data_last;
    logic                        end_from_next;
    logic                        start_to_next;

    modport master (
        input  start_from_previous, sink_ready, end_from_next,
        output end_to_previous, ifm_enable_read, ifm_address_read, ifm_sel_read,
               data_valid, data_last, start_to_next
    );

    modport slave (
        output start_from_previous, sink_ready, end_from_next,
        input  end_to_previous, ifm_enable_read, ifm_address_read, ifm_sel_read,
               data_valid, data_last, start_to_next
    );
endinterface

// File: rtl/poolb_valid_delay.sv
// Fixed-depth shift register aligning read-enable side-band with memory read data.
// Latency DEPTH cycles; synchronous active-low clear empties every stage.
// No backpressure: advances every cycle.
module poolb_valid_delay #(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DEPTH*DATA_WIDTH-1:0] sr;

    if (DEPTH == 1) begin : g_one
        always_ff @(posedge clk) begin
            if (!reset) sr <= '0;
            else        sr <= din;
        end
    end else begin : g_many
        always_ff @(posedge clk) begin
            if (!reset) sr <= '0;
            else        sr <= {sr[(DEPTH-1)*DATA_WIDTH-1:0], din};
        end
    end

    assign dout = sr[DEPTH*DATA_WIDTH-1 -: DATA_WIDTH];
endmodule

// File: rtl/poolb_next_reader_cu.sv
// Reads one IFM plane per producer start, cycling unit groups, then starts the next layer.
// data_valid/data_last trail ifm_enable_read by MEM_READ_LATENCY cycles.
// sink_ready gates each read combinationally; address holds while it is low.
module poolb_next_reader_cu
    import poolb_next_reader_cu_pkg::*;
#(
    parameter int IFM_SIZE         = IFM_SIZE_DEF,
    parameter int IFM_DEPTH        = IFM_DEPTH_DEF,
    parameter int NUMBER_OF_UNITS  = NUMBER_OF_UNITS_DEF,
    parameter int MEM_READ_LATENCY = MEM_READ_LATENCY_DEF
)(
    input  logic                   clk,
    input  logic                   reset,
    poolb_next_reader_cu_if.master bus
);
    localparam int NUMBER_OF_BLOCKS = ceil_div(IFM_DEPTH, NUMBER_OF_UNITS);
    localparam int ADDRESS_SIZE_IFM = width_of(IFM_SIZE * IFM_SIZE);
    localparam int SEL_SIZE         = width_of(NUMBER_OF_BLOCKS);
    localparam int CNT_SIZE         = 3;

    localparam logic [ADDRESS_SIZE_IFM-1:0] ADDR_MAX = ADDRESS_SIZE_IFM'(IFM_SIZE * IFM_SIZE - 1);
    localparam logic [SEL_SIZE-1:0]         SEL_MAX  = SEL_SIZE'(NUMBER_OF_BLOCKS - 1);
    localparam logic [CNT_SIZE-1:0]         CNT_LAST = CNT_SIZE'(MEM_READ_LATENCY - 1);

    state_t                      state_q, state_d;
    logic [ADDRESS_SIZE_IFM-1:0] addr_q, addr_d;
    logic [SEL_SIZE-1:0]         sel_q, sel_d;
    logic [CNT_SIZE-1:0]         cnt_q, cnt_d;
    logic                        pending_q, pending_d;
    logic                        rd_en, end_to_prev, start_next;
    logic [1:0]                  pipe_in, pipe_out;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        rd_en       = 1'b0;
        end_to_prev = 1'b0;
        start_next  = 1'b0;
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                end_to_prev = 1'b1;
                if (bus.start_from_previous) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                end
            end
            ST_READ: begin
                rd_en = bus.sink_ready;
                if (bus.sink_ready) begin
                    if (addr_q == ADDR_MAX) begin
                        addr_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            // Hold the bank until the final word has left the memory pipeline.
            ST_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    sel_d   = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
                    state_d = (sel_q == SEL_MAX) ? ST_HANDOFF : ST_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // A start landing while downstream is busy is remembered and replayed on handoff.
            ST_HANDOFF: begin
                end_to_prev = 1'b1;
                start_next  = bus.end_from_next;
                if (bus.end_from_next) begin
                    state_d   = (pending_q || bus.start_from_previous) ? ST_READ : ST_IDLE;
                    addr_d    = '0;
                    pending_d = 1'b0;
                end else if (bus.start_from_previous) begin
                    pending_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pipe_in = {rd_en & (addr_q == ADDR_MAX), rd_en};

    poolb_valid_delay #(
        .DATA_WIDTH (2),
        .DEPTH      (MEM_READ_LATENCY)
    ) u_valid_delay (
        .clk   (clk),
        .reset (reset),
        .din   (pipe_in),
        .dout  (pipe_out)
    );

    assign bus.end_to_previous  = end_to_prev;
    assign bus.ifm_enable_read  = rd_en;
    assign bus.ifm_address_read = addr_q;
    assign bus.ifm_sel_read     = sel_q;
    assign bus.data_valid       = pipe_out[0];
    assign bus.data_last        = pipe_out[1];
    assign bus.start_to_next    = start_next;
endmodule

// File: tb/tb_poolb_next_reader_cu.sv
// Cycle-by-cycle vector bench for the next-IFM reader control unit.
module tb_poolb_next_reader_cu;
    import poolb_next_reader_cu_pkg::*;

    typedef struct packed {
        logic rst_n;
        logic start;
        logic sink;
        logic efn;
    } in_t;

    typedef struct packed {
        logic       en;
        logic [3:0] addr;
        logic [2:0] sel;
        logic       vld;
        logic       last;
        logic       e2p;
        logic       s2n;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int WAIT_LIMIT = 5000;

    logic clk = 1'b0;
    logic reset;
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    poolb_next_reader_cu_if #(
        .ADDRESS_SIZE_IFM (4),
        .SEL_SIZE         (3)
    ) bus ();

    poolb_next_reader_cu #(
        .IFM_SIZE         (3),
        .IFM_DEPTH        (16),
        .NUMBER_OF_UNITS  (3),
        .MEM_READ_LATENCY (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) begin
        cyc++;
        if (cyc > WAIT_LIMIT) begin
            $display("FAIL: wait expired after %0d cycles", cyc);
            $finish;
        end
    end

    function automatic vec_t v(input logic r, s, k, e, en, input int a, input int sl,
                               input logic vd, l, ep, sn);
        vec_t x;
        x.i = '{rst_n: r, start: s, sink: k, efn: e};
        x.o = '{en: en, addr: 4'(a), sel: 3'(sl), vld: vd, last: l, e2p: ep, s2n: sn};
        return x;
    endfunction

    // Start pulse seen in IDLE/FINISH: no read yet, bank still released.
    task automatic push_start(input int sel);
        tbl.push_back(v(1, 1, 1, 0, 0, 0, sel, 0, 0, 1, 0));
    endtask

    // Nine back-to-back reads then the single drain cycle carrying the last word.
    task automatic push_reads(input int sel, input int mid_start);
        for (int k = 0; k < 9; k++)
            tbl.push_back(v(1, k == mid_start, 1, 0, 1, k, sel, k > 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, sel, 1, 1, 0, 0));
    endtask

    initial begin
        int   a;
        logic pen, plast, s;

        // reset state
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        // plane 0, sink always ready
        push_start(0);
        push_reads(0, -1);
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        // plane 1 with sink_ready pattern 1,0,0,...
        push_start(1);
        a = 0; pen = 0; plast = 0;
        for (int i = 0; a < 9; i++) begin
            s = (i % 3 == 0);
            tbl.push_back(v(1, 0, s, 0, s, (a == 9) ? 0 : a, 1, pen, plast, 0, 0));
            plast = s && (a == 8);
            pen   = s;
            if (s) a++;
        end
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 2, 0, 0, 1, 0));
        // plane 2 with a stray start at address 4
        push_start(2);
        push_reads(2, 4);
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 3, 0, 0, 1, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 3, 0, 0, 1, 0));
        // planes 3..5 back to back, then handoff with downstream idle
        for (int p = 3; p < 6; p++) begin
            push_start(p);
            push_reads(p, -1);
        end
        tbl.push_back(v(1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(v(1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        // second pass: downstream busy in handoff, start arrives meanwhile
        for (int p = 0; p < 6; p++) begin
            push_start(p);
            push_reads(p, -1);
        end
        for (int c = 0; c < 5; c++)
            tbl.push_back(v(1, c == 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1));
        push_reads(0, -1);
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        // reset mid-plane at address 5
        push_start(1);
        for (int k = 0; k < 6; k++)
            tbl.push_back(v(k != 5, 0, 1, 0, 1, k, 1, k > 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));

        reset = 1'b0;
        bus.start_from_previous = 1'b0;
        bus.sink_ready = 1'b1;
        bus.end_from_next = 1'b0;
        repeat (2) @(posedge clk);

        #1;
        n_checks++;
        if (bus.end_to_previous === 1'b1 && bus.ifm_enable_read === 1'b0 &&
            bus.data_valid === 1'b0 && bus.data_last === 1'b0 &&
            bus.start_to_next === 1'b0 && bus.ifm_address_read === 4'd0 &&
            bus.ifm_sel_read === 3'd0) begin
            n_pass++;
        end else begin
            $display("FAIL reset state: en=%b addr=%0d sel=%0d vld=%b last=%b e2p=%b s2n=%b",
                     bus.ifm_enable_read, bus.ifm_address_read, bus.ifm_sel_read,
                     bus.data_valid, bus.data_last, bus.end_to_previous, bus.start_to_next);
        end

        foreach (tbl[idx]) begin
            out_t act;
            @(negedge clk);
            reset                   = tbl[idx].i.rst_n;
            bus.start_from_previous = tbl[idx].i.start;
            bus.sink_ready          = tbl[idx].i.sink;
            bus.end_from_next       = tbl[idx].i.efn;
            #1;
            act = '{en: bus.ifm_enable_read, addr: bus.ifm_address_read,
                    sel: bus.ifm_sel_read, vld: bus.data_valid, last: bus.data_last,
                    e2p: bus.end_to_previous, s2n: bus.start_to_next};
            n_checks++;
            if (act === tbl[idx].o) begin
                n_pass++;
            end else begin
                $display("FAIL row %0d: got en=%b addr=%0d sel=%0d vld=%b last=%b e2p=%b s2n=%b, want en=%b addr=%0d sel=%0d vld=%b last=%b e2p=%b s2n=%b",
                         idx, act.en, act.addr, act.sel, act.vld, act.last, act.e2p, act.s2n,
                         tbl[idx].o.en, tbl[idx].o.addr, tbl[idx].o.sel, tbl[idx].o.vld,
                         tbl[idx].o.last, tbl[idx].o.e2p, tbl[idx].o.s2n);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
